// File: rtl/sweep_pkg.sv
// Shared encodings for the sweep controller: sweep modes and FSM states.
package sweep_pkg;

    typedef enum logic [1:0] {
        MODE_UP_WRAP   = 2'd0,
        MODE_DOWN_WRAP = 2'd1,
        MODE_PINGPONG  = 2'd2,
        MODE_SINGLE    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sweep_ctrl_if.sv
// Control/status bundle of the sweep controller; the master drives commands, the slave reports the sweep.
interface sweep_ctrl_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, mode, limit,
        input  count, dir, busy, done
    );

    modport slave (
        input  start, stop, mode, limit,
        output count, dir, busy, done
    );
endinterface

// File: rtl/updown_counter.sv
// Loadable up/down counter; load wins over a step, all arithmetic wraps modulo 2^WIDTH.
module updown_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= dir ? count + 1'b1 : count - 1'b1;
        end
    end

endmodule

// File: rtl/sweep_ctrl.sv
// Sweep sequencer driving an updown_counter. Define SWEEP_CTRL_PRESCALE_EN to step once every
// PRESCALE cycles instead of every cycle.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int PRESCALE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    sweep_ctrl_if.slave  bus
);

    state_t           state, state_nxt;
    mode_t            mode_r;
    logic [WIDTH-1:0] lim_r, lim_eff, count, load_val;
    logic             dir_r, dir_nxt, busy_r, done_r;
    logic             tick, go, at_top, at_bottom;
    logic             cnt_en, cnt_dir, cnt_load;

    assign lim_eff   = (bus.limit == '0) ? '1 : bus.limit;
    assign go        = bus.start && !bus.stop;
    assign at_top    = (count == lim_r);
    assign at_bottom = (count == '0);

`ifdef SWEEP_CTRL_PRESCALE_EN
    // One-hot ring: the tick fires when the token reaches the top bit, PRESCALE cycles after a clear.
    logic [PRESCALE-1:0] phase;

    always_ff @(posedge clk) begin
        if (!rst_n || state != RUN || bus.stop) begin
            phase <= PRESCALE'(1);
        end else begin
            phase <= (phase << 1) | PRESCALE'(phase[PRESCALE-1]);
        end
    end

    assign tick = phase[PRESCALE-1];
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_r;
        cnt_en    = 1'b0;
        cnt_dir   = 1'b1;
        cnt_load  = 1'b0;
        load_val  = '0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = RUN;
                    cnt_load  = 1'b1;
                    if (mode_t'(bus.mode) == MODE_DOWN_WRAP) begin
                        load_val = lim_eff;
                        dir_nxt  = 1'b0;
                    end else begin
                        dir_nxt  = 1'b1;
                    end
                end
            end
            RUN: begin
                // A single sweep ends as soon as the counter sits on the limit, without waiting for a tick.
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (mode_r == MODE_SINGLE && at_top) begin
                    state_nxt = DONE;
                end else if (tick) begin
                    unique case (mode_r)
                        MODE_UP_WRAP: begin
                            if (at_top) cnt_load = 1'b1;
                            else        cnt_en   = 1'b1;
                        end
                        MODE_DOWN_WRAP: begin
                            if (at_bottom) begin
                                cnt_load = 1'b1;
                                load_val = lim_r;
                            end else begin
                                cnt_en  = 1'b1;
                                cnt_dir = 1'b0;
                            end
                        end
                        MODE_PINGPONG: begin
                            cnt_en = 1'b1;
                            if (dir_r) begin
                                if (at_top) begin
                                    cnt_dir = 1'b0;
                                    dir_nxt = 1'b0;
                                end
                            end else if (at_bottom) begin
                                dir_nxt = 1'b1;
                            end else begin
                                cnt_dir = 1'b0;
                            end
                        end
                        MODE_SINGLE: cnt_en = 1'b1;
                        default:     cnt_en = 1'b0;
                    endcase
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            mode_r <= MODE_UP_WRAP;
            lim_r  <= '1;
            dir_r  <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            dir_r  <= dir_nxt;
            busy_r <= (state_nxt == RUN);
            done_r <= (state_nxt == DONE);
            if (state == IDLE && go) begin
                mode_r <= mode_t'(bus.mode);
                lim_r  <= lim_eff;
            end
        end
    end

    updown_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (cnt_en),
        .dir      (cnt_dir),
        .load     (cnt_load),
        .load_val (load_val),
        .count    (count)
    );

    assign bus.count = count;
    assign bus.dir   = dir_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3: count width in bits.
REQ-002 The block SHALL have parameter PRESCALE, default 4: clock cycles per count step when prescaling is compiled in.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: begin a sweep; sampled only in IDLE.
REQ-006 The block SHALL have port stop, input, 1 bit: abort the current sweep.
REQ-007 The block SHALL have port mode, input, 2 bits: 0 = up-wrap, 1 = down-wrap, 2 = ping-pong, 3 = single sweep up.
REQ-008 The block SHALL have port limit, input, WIDTH bits: top count value; 0 means all-ones.
REQ-009 The block SHALL have port count, output, WIDTH bits: current counter value.
REQ-010 The block SHALL have port dir, output, 1 bit: current direction, 1 = up.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a single sweep.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 and stop=0, the block SHALL capture mode and the effective limit (L) and go to RUN at the next edge.
REQ-015 On entry to RUN, count SHALL load L for down-wrap and 0 for every other mode; dir SHALL load 0 for down-wrap and 1 otherwise.
REQ-016 A step SHALL occur on each tick while in RUN; the first tick SHALL come one tick period after the RUN entry edge.
REQ-017 Up-wrap: count SHALL step 0,1,...,L,0,1,... with L to 0 in a single step.
REQ-018 Down-wrap: count SHALL step L,...,0,L,... with 0 to L in a single step.
REQ-019 Ping-pong: at count==L going up, dir SHALL flip to 0 and count SHALL become L-1 on the same step; at count==0 going down, dir SHALL flip to 1 and count SHALL become 1. When L==1 the sequence SHALL be 0,1,0,1.
REQ-020 Single: count SHALL step up to L; the step that reaches L SHALL move the FSM to DONE, with done=1 for exactly one cycle, then IDLE. count SHALL hold at L.
REQ-021 stop=1 in RUN SHALL force IDLE at the next edge, hold count, and take priority over a coincident step. No done pulse SHALL be produced.
REQ-022 start and stop both high in IDLE SHALL leave the block in IDLE.
REQ-023 start SHALL be ignored in RUN and DONE.
REQ-024 mode and limit changes during RUN SHALL have no effect until the next start.
REQ-025 busy SHALL equal (state==RUN), registered, with no combinational path from any input.
REQ-026 All arithmetic SHALL be modulo 2^WIDTH; count SHALL never exceed L while in RUN.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force state=IDLE, count=0, dir=1, busy=0, done=0, and clear the prescaler, including mid-sweep.
REQ-028 Release of reset SHALL take effect at the first edge with rst_n=1, and no output SHALL change in that cycle.

Configuration
REQ-029 With SWEEP_CTRL_PRESCALE_EN defined, the tick SHALL be asserted once every PRESCALE cycles from a counter cleared on RUN entry, on stop and on reset.
REQ-030 Without SWEEP_CTRL_PRESCALE_EN, the tick SHALL be constant 1 (one step per cycle in RUN), PRESCALE SHALL be unused, and no prescaler flops SHALL exist.

Structure
REQ-031 The mode encodings (MODE_UP_WRAP, MODE_DOWN_WRAP, MODE_PINGPONG, MODE_SINGLE) and the state encodings SHALL live in shared package sweep_pkg.
REQ-032 The counter datapath SHALL be sub-module updown_counter, with ports clk, rst_n, en, dir, load, load_val and count.
REQ-033 sweep_ctrl SHALL drive en, dir and load of updown_counter only, and SHALL contain no adders itself.

Verification
REQ-034 Reset mid-sweep: up-wrap L=5, assert rst_n=0 at count=3 -> next cycle count=0, busy=0, state IDLE.
REQ-035 Up-wrap: L=5, no prescale -> count 0,1,2,3,4,5,0,1 on consecutive cycles, busy=1.
REQ-036 Ping-pong: L=3 -> 0,1,2,3,2,1,0,1; dir falls on the cycle count becomes 2.
REQ-037 Single: limit=0 (L=7) -> 0..7, done high for one cycle after count=7, then IDLE and busy=0.
REQ-038 Stop: down-wrap L=4, stop at count=2 coinciding with a tick -> count stays 2, IDLE, done=0; start+stop together in IDLE -> no change.
REQ-039 Prescale: with SWEEP_CTRL_PRESCALE_EN and PRESCALE=4, up-wrap L=2 -> count changes every 4th cycle; start pulsed during RUN is ignored.
